usb_rx_data_ctrl: RTL and testbench
===================================

Name: usb_rx_data_ctrl

Overview:
- Sequences the USB receive-side DATA0/DATA1 packet path once the PID decoder has recognised a data PID.
- Feeds every received byte into the shared CRC16 checker, including the two trailing CRC bytes.
- Holds back the last two bytes in a 2-deep delay buffer so that only payload reaches the endpoint buffer.
- At end of packet, samples the checker's residual-match flag and reports packet status and payload length to the SIE state machine.

Parameters:
- MAX_PAYLOAD, 1023, largest legal payload in bytes (full-speed isochronous limit).
- LEN_W, 11, width of the payload length counter/output. Must satisfy 2^LEN_W > MAX_PAYLOAD+2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  1-cycle strobe from PID decoder: data PID received, packet body follows
- byte_in  input  8  received byte from the deserializer
- byte_valid  input  1  byte_in valid this cycle
- eop  input  1  1-cycle end-of-packet strobe
- rx_error  input  1  bit-stuff or line error strobe; aborts the packet
- crc_valid  input  1  CRC16 checker residual-match flag (registered inside the checker)
- crc_init  output  1  1-cycle pulse that re-initialises the checker LFSR to 0xFFFF
- crc_en  output  1  checker update enable
- crc_data  output  8  byte presented to the checker
- out_data  output  8  payload byte to the endpoint buffer
- out_valid  output  1  out_data valid (1-cycle pulse per byte)
- pkt_done  output  1  1-cycle status strobe
- pkt_ok  output  1  CRC good and length legal; held until next start
- pkt_len  output  LEN_W  payload byte count (total bytes − 2); held until next start
- pkt_err  output  1  1-cycle pulse on abort, CRC failure or length violation

Behaviour:
- Reset: state IDLE. All outputs 0. Buffer and counters cleared.
- Reset mid-packet: immediate return to IDLE. No pkt_done is produced.
- States: IDLE, FILL0, FILL1, STREAM, CHECK, REPORT.
- IDLE:
  - start=1 → crc_init=1 (combinational) the same cycle, clear pkt_ok/pkt_len/byte count, next state FILL0.
  - A byte_valid coincident with start is ignored.
  - start in any other state is ignored.
- crc_en = byte_valid AND state∈{FILL0, FILL1, STREAM}. crc_data = byte_in, combinational pass-through.
- FILL0: on byte_valid, hold0←byte, count=1, → FILL1.
- FILL1: on byte_valid, hold1←byte, count=2, → STREAM.
- STREAM, on byte_valid:
  - out_data←hold0 and out_valid=1 on the next cycle, so forwarding latency is 1 clock.
  - hold0←hold1, hold1←byte, count+1.
- Byte count saturates at MAX_PAYLOAD+3.
  - Once count > MAX_PAYLOAD+2, forwarding stops (out_valid stays 0) and the length-violation flag is set.
- eop in FILL0/FILL1/STREAM → CHECK.
  - If byte_valid and eop are asserted in the same cycle, the byte is accepted first and then the packet terminates.
- CHECK (1 cycle): crc_valid now reflects all bytes. Register crc_ok, then → REPORT.
- REPORT (1 cycle):
  - pkt_done=1.
  - pkt_len = count−2, or 0 if count<2.
  - pkt_ok = crc_ok AND count≥2 AND no length violation.
  - pkt_err = NOT pkt_ok.
  - → IDLE.
- Latency: eop at cycle T → pkt_done at T+2.
- The two held CRC bytes are never forwarded.
- rx_error in any non-IDLE state:
  - → IDLE next cycle, pkt_err=1 for that cycle, pkt_ok=0, no pkt_done.
  - Bytes already forwarded are not retracted; the endpoint buffer discards on pkt_err.
- byte_valid in IDLE, CHECK or REPORT: ignored, crc_en=0.
- crc_valid is sampled only in CHECK. Its value at any other time has no effect.

Decomposition:
- Shared package usb_rx_pkg:
  - state enum typedef rx_data_state_t
  - MAX_PAYLOAD default constant
  - CRC16 init value 16'hFFFF
- Sub-module usb_byte_delay2: 2-entry shift buffer with load/shift enables and a held-count output.
- The CRC16 checker is instantiated at the SIE level, not inside this block. Its reset is driven from rst OR crc_init.

Test Plan:
- Zero-length packet: start, then bytes 0x00, 0x00, then eop with crc_valid=1 in CHECK → out_valid never asserts, pkt_done at eop+2, pkt_ok=1, pkt_len=0.
- 4-byte payload 0x01 0x02 0x03 0x04 plus model-computed CRC → out_valid pulses exactly 4 times, carrying 01..04 in order, each 1 cycle after bytes 3..6 respectively; pkt_ok=1, pkt_len=4.
- Same packet with one CRC bit flipped → crc_valid=0 in CHECK; pkt_done=1, pkt_ok=0, pkt_err=1, pkt_len=4.
- eop after a single byte → pkt_done=1, pkt_len=0, pkt_ok=0, pkt_err=1, no out_valid.
- rx_error asserted after 3 bytes → pkt_err pulse next cycle, state IDLE, no pkt_done; a new start then produces a good packet.
- Bytes with MAX_PAYLOAD=4: 8 bytes then eop → exactly 4 out_valid pulses, pkt_ok=0, pkt_err=1. Also: byte_valid coincident with eop is counted; byte_valid coincident with start is not; rst asserted mid-STREAM forces all outputs to 0 immediately.

Source files
------------

// File: rtl/usb_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_pkg
// Description : Shared types and constants for the USB receive data path.
//               Holds the data-stage state encoding, the default payload
//               limit, the CRC16 seed and a payload-length helper.
// Revision    : 1.0  initial release
// ============================================================================
package usb_rx_pkg;

  // Largest legal data payload (full-speed isochronous).
  localparam int c_max_payload_def = 1023;

  // Seed loaded into the CRC16 checker LFSR at the start of each packet.
  localparam logic [15:0] c_crc16_init = 16'hFFFF;

  // Data-stage sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL0  = 3'd1,
    ST_FILL1  = 3'd2,
    ST_STREAM = 3'd3,
    ST_CHECK  = 3'd4,
    ST_REPORT = 3'd5
  } rx_data_state_t;

  // Payload length from the total byte count: the last two bytes are CRC.
  function automatic int payload_len(input int count);
    return (count < 2) ? 0 : count - 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_data_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_data_ctrl_if
// Description : Bundle of the receive data controller's data-path signals.
//               slave  : the data controller itself
//               master : the SIE side (PID decoder, deserializer, CRC16
//                        checker, endpoint buffer, SIE state machine)
//   start/byte_in/byte_valid/eop/rx_error : packet body from the receiver
//   crc_valid                             : checker residual-match flag
//   crc_init/crc_en/crc_data              : checker control and data
//   out_data/out_valid                    : payload to the endpoint buffer
//   pkt_done/pkt_ok/pkt_len/pkt_err       : packet status to the SIE
// Revision    : 1.0  initial release
// ============================================================================
interface usb_rx_data_ctrl_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             eop;
  logic             rx_error;
  logic             crc_valid;
  logic             crc_init;
  logic             crc_en;
  logic [7:0]       crc_data;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             pkt_done;
  logic             pkt_ok;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_err;

  modport slave (
    input  start, byte_in, byte_valid, eop, rx_error, crc_valid,
    output crc_init, crc_en, crc_data, out_data, out_valid,
           pkt_done, pkt_ok, pkt_len, pkt_err
  );

  modport master (
    output start, byte_in, byte_valid, eop, rx_error, crc_valid,
    input  crc_init, crc_en, crc_data, out_data, out_valid,
           pkt_done, pkt_ok, pkt_len, pkt_err
  );
endinterface
`default_nettype wire

// File: rtl/usb_byte_delay2.sv
`default_nettype none
// ============================================================================
// Module      : usb_byte_delay2
// Description : Two-entry byte shift buffer. Keeps the most recent two bytes
//               so the trailing CRC bytes are still held when the packet ends.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : empty the buffer (start of a new packet)
//   load_en   : write din into the next free slot (fill phase)
//   shift_en  : drop the head, append din at the tail (stream phase)
//   din       : incoming byte
//   head      : oldest held byte (next byte to leave)
//   held      : number of bytes currently held (0..2)
// Revision    : 1.0  initial release
// ============================================================================
module usb_byte_delay2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load_en,
  input  logic       shift_en,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic [1:0] held
);

  logic [7:0] r_hold0;
  logic [7:0] r_hold1;
  logic [1:0] r_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold0 <= 8'h00;
      r_hold1 <= 8'h00;
      r_held  <= 2'd0;
    end else if (clr) begin
      r_hold0 <= 8'h00;
      r_hold1 <= 8'h00;
      r_held  <= 2'd0;
    end else if (load_en) begin
      if (r_held == 2'd0) begin
        r_hold0 <= din;
        r_held  <= 2'd1;
      end else begin
        r_hold1 <= din;
        r_held  <= 2'd2;
      end
    end else if (shift_en) begin
      r_hold0 <= r_hold1;
      r_hold1 <= din;
      r_held  <= 2'd2;
    end
  end

  assign head = r_hold0;
  assign held = r_held;

endmodule
`default_nettype wire

// File: rtl/usb_rx_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_data_ctrl
// Description : USB receive DATA0/DATA1 packet sequencer. Feeds every body
//               byte to the external CRC16 checker, holds back the last two
//               bytes so only payload reaches the endpoint buffer, and
//               reports status and payload length at end of packet.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : usb_rx_data_ctrl_if.slave (receiver inputs, checker control,
//              endpoint payload stream, packet status)
// Revision    : 1.0  initial release
// ============================================================================
module usb_rx_data_ctrl
  import usb_rx_pkg::*;
#(
  parameter int MAX_PAYLOAD = c_max_payload_def,
  // 2**LEN_W must exceed MAX_PAYLOAD+2 so the saturated count fits.
  parameter int LEN_W       = 11
) (
  input  logic                clk,
  input  logic                rst,
  usb_rx_data_ctrl_if.slave   bus
);

  // Highest count at which a byte may still release payload, and the
  // saturation value that marks an over-length packet.
  localparam logic [LEN_W-1:0] c_fwd_limit = LEN_W'(MAX_PAYLOAD + 2);
  localparam logic [LEN_W-1:0] c_cnt_sat   = LEN_W'(MAX_PAYLOAD + 3);
  localparam logic [LEN_W-1:0] c_one       = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_two       = LEN_W'(2);

  rx_data_state_t   r_state;
  logic [LEN_W-1:0] r_count;
  logic             r_len_viol;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_pkt_done;
  logic             r_pkt_ok;
  logic [LEN_W-1:0] r_pkt_len;
  logic             r_pkt_err;

  logic       w_in_body;
  logic       w_start;
  logic       w_abort;
  logic       w_take;
  logic       w_can_fwd;
  logic       w_pkt_good;
  logic [7:0] w_head;
  logic [1:0] w_held;

  assign w_in_body  = (r_state == ST_FILL0) || (r_state == ST_FILL1) ||
                      (r_state == ST_STREAM);
  assign w_start    = (r_state == ST_IDLE) && bus.start;
  assign w_abort    = (r_state != ST_IDLE) && bus.rx_error;
  assign w_take     = bus.byte_valid && w_in_body;
  // A byte releases the head only while the packet is still within the
  // legal length; past that the payload is truncated.
  assign w_can_fwd  = (w_held == 2'd2) && (r_count < c_fwd_limit);
  // In CHECK the checker has absorbed the final byte, so crc_valid is
  // sampled directly into the status registers; pkt_ok then holds it.
  assign w_pkt_good = bus.crc_valid && (r_count >= c_two) && !r_len_viol;

  usb_byte_delay2 u_delay (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_start),
    .load_en  (w_take && ((r_state == ST_FILL0) || (r_state == ST_FILL1))),
    .shift_en (w_take && (r_state == ST_STREAM)),
    .din      (bus.byte_in),
    .head     (w_head),
    .held     (w_held)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_len_viol  <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_ok    <= 1'b0;
      r_pkt_len   <= '0;
      r_pkt_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_pkt_done  <= 1'b0;
      r_pkt_err   <= 1'b0;
      if (w_abort) begin
        // Forwarded bytes stay forwarded; the endpoint drops them on pkt_err.
        r_state   <= ST_IDLE;
        r_pkt_err <= 1'b1;
        r_pkt_ok  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_pkt_ok   <= 1'b0;
              r_pkt_len  <= '0;
              r_count    <= '0;
              r_len_viol <= 1'b0;
              r_state    <= ST_FILL0;
            end
          end
          ST_FILL0: begin
            if (bus.byte_valid) begin
              r_count <= c_one;
              r_state <= ST_FILL1;
            end
            if (bus.eop) r_state <= ST_CHECK;
          end
          ST_FILL1: begin
            if (bus.byte_valid) begin
              r_count <= c_two;
              r_state <= ST_STREAM;
            end
            if (bus.eop) r_state <= ST_CHECK;
          end
          ST_STREAM: begin
            if (bus.byte_valid) begin
              if (w_can_fwd) begin
                r_out_data  <= w_head;
                r_out_valid <= 1'b1;
                r_count     <= r_count + c_one;
              end else begin
                r_count    <= c_cnt_sat;
                r_len_viol <= 1'b1;
              end
            end
            if (bus.eop) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            r_pkt_done <= 1'b1;
            r_pkt_ok   <= w_pkt_good;
            r_pkt_err  <= !w_pkt_good;
            r_pkt_len  <= LEN_W'(payload_len(int'(r_count)));
            r_state    <= ST_REPORT;
          end
          ST_REPORT: begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.crc_init  = w_start;
  assign bus.crc_en    = w_take;
  assign bus.crc_data  = bus.byte_in;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.pkt_done  = r_pkt_done;
  assign bus.pkt_ok    = r_pkt_ok;
  assign bus.pkt_len   = r_pkt_len;
  assign bus.pkt_err   = r_pkt_err;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_data_ctrl
// Description : Scoreboard bench for usb_rx_data_ctrl with a small payload
//               limit so length violations are reachable. Includes a model
//               of the external CRC16 checker driving crc_valid.
// Revision    : 1.0  initial release
// ============================================================================
module tb_usb_rx_data_ctrl;
  import usb_rx_pkg::*;

  localparam int MAXP = 4;
  localparam int LW   = 11;

  typedef struct { int cyc; logic [7:0] d; } out_t;
  typedef struct { int cyc; logic ok; int len; int ncrc; } stat_t;
  typedef struct { int cyc; int ncrc; } abt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   crc_cnt = 0;
  bit   real_start = 0;
  logic held_ok = 1'b0;
  int   held_len = 0;

  out_t  q_out[$];
  stat_t q_stat[$];
  abt_t  q_abt[$];
  out_t  e_out;
  stat_t e_stat;
  abt_t  e_abt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_rx_data_ctrl_if #(.LEN_W(LW)) bus ();

  usb_rx_data_ctrl #(.MAX_PAYLOAD(MAXP), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---- CRC16 (USB, reflected poly 0xA001) -------------------------------
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Residual is the same for every correctly-terminated packet; the empty
  // payload (CRC bytes 00 00) gives it directly.
  function automatic logic [15:0] crc_res();
    return crc_upd(crc_upd(16'hFFFF, 8'h00), 8'h00);
  endfunction

  function automatic bit crc_good(input logic [7:0] pk[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pk[k]) c = crc_upd(c, pk[k]);
    return c == crc_res();
  endfunction

  // External checker stand-in: registered residual-match flag.
  logic [15:0] m_crc;
  logic        m_valid;
  always @(posedge clk or posedge rst) begin
    if (rst || bus.crc_init) begin
      m_crc   <= 16'hFFFF;
      m_valid <= 1'b0;
    end else if (bus.crc_en) begin
      m_crc   <= crc_upd(m_crc, bus.crc_data);
      m_valid <= (crc_upd(m_crc, bus.crc_data) == crc_res());
    end
  end
  assign bus.crc_valid = m_valid;

  // ---- checking ---------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.crc_init) crc_cnt = 0;
      else if (bus.crc_en) crc_cnt++;
      if (real_start) begin
        chk("held_pkt_ok", 32'(bus.pkt_ok), 32'(held_ok));
        chk("held_pkt_len", 32'(bus.pkt_len), 32'(held_len));
      end
      if (bus.out_valid) begin
        if (q_out.size() == 0) chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        else begin
          e_out = q_out.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e_out.d));
          chk("out_cycle", 32'(cyc), 32'(e_out.cyc));
        end
      end
      if (bus.pkt_done) begin
        if (q_stat.size() == 0) chk("unexpected_pkt_done", 32'(bus.pkt_done), 32'd0);
        else begin
          e_stat = q_stat.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e_stat.cyc));
          chk("pkt_ok", 32'(bus.pkt_ok), 32'(e_stat.ok));
          chk("pkt_err", 32'(bus.pkt_err), 32'(!e_stat.ok));
          chk("pkt_len", 32'(bus.pkt_len), 32'(e_stat.len));
          chk("crc_en_count", 32'(crc_cnt), 32'(e_stat.ncrc));
          held_ok  = e_stat.ok;
          held_len = e_stat.len;
        end
      end else if (bus.pkt_err) begin
        if (q_abt.size() == 0) chk("unexpected_pkt_err", 32'(bus.pkt_err), 32'd0);
        else begin
          e_abt = q_abt.pop_front();
          chk("abort_cycle", 32'(cyc), 32'(e_abt.cyc));
          chk("abort_pkt_ok", 32'(bus.pkt_ok), 32'd0);
          chk("abort_crc_en_count", 32'(crc_cnt), 32'(e_abt.ncrc));
          held_ok  = 1'b0;
          held_len = 0;
        end
      end
    end
  end

  // ---- stimulus ---------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input bit junk);
    bus.start      = 1'b0;
    bus.eop        = 1'b0;
    bus.rx_error   = 1'b0;
    bus.byte_valid = junk ? ($urandom_range(0, 2) == 0) : 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  // Reference rules: total N bytes, last two are CRC; payload byte j leaves
  // one clock after byte j+2 arrives, only the first MAXP payload bytes.
  task automatic push_status(input logic [7:0] pk[$], input int c);
    stat_t s;
    int n;
    n = pk.size();
    s.cyc  = c;
    s.len  = (n < 2) ? 0 : (((n < MAXP + 3) ? n : MAXP + 3) - 2);
    s.ok   = (n >= 2) && (n <= MAXP + 2) && crc_good(pk);
    s.ncrc = n;
    q_stat.push_back(s);
  endtask

  task automatic send_pkt(input logic [7:0] pk[$], input int abort_at,
                          input bit eop_last, input bit bv_start, input bit spur);
    int n;
    bit aborted;
    bit eop_sent;
    n = pk.size();
    aborted = 0;
    eop_sent = 0;
    drive_idle(0);
    bus.start = 1'b1;
    bus.byte_valid = bv_start;
    real_start = 1;
    tick();
    real_start = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        drive_idle(0);
        if (spur && $urandom_range(0, 2) == 0) bus.start = 1'b1;
        tick();
      end
      if (i == abort_at) begin
        aborted = 1;
        break;
      end
      drive_idle(0);
      bus.byte_valid = 1'b1;
      bus.byte_in    = pk[i];
      if (i >= 2 && i < MAXP + 2) q_out.push_back('{cyc + 1, pk[i-2]});
      if (eop_last && i == n - 1) begin
        bus.eop  = 1'b1;
        eop_sent = 1;
        push_status(pk, cyc + 2);
      end
      tick();
    end
    if (abort_at >= 0 && (aborted || abort_at == n)) begin
      drive_idle(0);
      bus.rx_error = 1'b1;
      q_abt.push_back('{cyc + 1, abort_at});
      tick();
    end else if (!eop_sent) begin
      drive_idle(0);
      bus.eop = 1'b1;
      push_status(pk, cyc + 2);
      tick();
    end
    repeat (4) begin
      drive_idle(1);
      tick();
    end
    drive_idle(0);
  endtask

  function automatic void make_pkt(input int plen, output logic [7:0] pk[$]);
    logic [15:0] c;
    pk = {};
    c = 16'hFFFF;
    for (int k = 0; k < plen; k++) begin
      pk.push_back(8'($urandom));
      c = crc_upd(c, pk[k]);
    end
    pk.push_back(~c[7:0]);
    pk.push_back(~c[15:8]);
  endfunction

  initial begin
    logic [7:0] pk[$];
    logic [15:0] c;
    int plen;
    int ab;
    drive_idle(0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_pkt_done", 32'(bus.pkt_done), 32'd0);
    chk("rst_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    chk("rst_pkt_len", 32'(bus.pkt_len), 32'd0);
    chk("rst_pkt_err", 32'(bus.pkt_err), 32'd0);
    chk("rst_crc_en", 32'(bus.crc_en), 32'd0);
    chk("rst_crc_init", 32'(bus.crc_init), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // zero-length payload
    pk = {8'h00, 8'h00};
    send_pkt(pk, -1, 0, 0, 0);
    // 4-byte payload, good CRC (exactly at the length limit)
    c = 16'hFFFF;
    pk = {8'h01, 8'h02, 8'h03, 8'h04};
    foreach (pk[k]) c = crc_upd(c, pk[k]);
    pk.push_back(~c[7:0]);
    pk.push_back(~c[15:8]);
    send_pkt(pk, -1, 0, 0, 0);
    // same packet, one CRC bit flipped
    pk[5] = pk[5] ^ 8'h10;
    send_pkt(pk, -1, 0, 0, 0);
    // single byte then eop
    pk = {8'h5A};
    send_pkt(pk, -1, 0, 0, 0);
    // abort after 3 bytes, then a good packet
    make_pkt(3, pk);
    send_pkt(pk, 3, 0, 0, 0);
    make_pkt(3, pk);
    send_pkt(pk, -1, 0, 0, 0);
    // 8 bytes total: over-length
    make_pkt(6, pk);
    send_pkt(pk, -1, 0, 0, 0);
    // eop with last byte, byte_valid with start, spurious start mid-packet
    make_pkt(3, pk);
    send_pkt(pk, -1, 1, 1, 1);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 9) == 0) begin
        pk = {};
        repeat ($urandom_range(0, 1)) pk.push_back(8'($urandom));
      end else begin
        plen = $urandom_range(0, 7);
        make_pkt(plen, pk);
      end
      if (pk.size() > 0 && $urandom_range(0, 4) == 0) begin
        ab = $urandom_range(0, pk.size() - 1);
        pk[ab] = pk[ab] ^ (8'h01 << $urandom_range(0, 7));
      end
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, pk.size()) : -1;
      send_pkt(pk, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    // reset asserted mid-STREAM while out_valid is high
    make_pkt(4, pk);
    drive_idle(0);
    bus.start = 1'b1;
    real_start = 1;
    tick();
    real_start = 0;
    for (int i = 0; i < 4; i++) begin
      drive_idle(0);
      bus.byte_valid = 1'b1;
      bus.byte_in    = pk[i];
      if (i == 2) q_out.push_back('{cyc + 1, pk[0]});
      tick();
    end
    drive_idle(0);
    bus.byte_valid = 1'b1;
    bus.byte_in    = pk[4];
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_out_data", 32'(bus.out_data), 32'(pk[1]));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data), 32'd0);
    chk("midrst_crc_en", 32'(bus.crc_en), 32'd0);
    chk("midrst_pkt_done", 32'(bus.pkt_done), 32'd0);
    chk("midrst_pkt_err", 32'(bus.pkt_err), 32'd0);
    chk("midrst_pkt_ok", 32'(bus.pkt_ok), 32'd0);
    chk("midrst_pkt_len", 32'(bus.pkt_len), 32'd0);
    drive_idle(0);
    tick();
    rst = 1'b0;
    held_ok = 1'b0;
    held_len = 0;
    repeat (3) tick();
    make_pkt(2, pk);
    send_pkt(pk, -1, 0, 0, 0);

    repeat (10) tick();
    chk("leftover_out", 32'(q_out.size()), 32'd0);
    chk("leftover_status", 32'(q_stat.size()), 32'd0);
    chk("leftover_abort", 32'(q_abt.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
